// File: rtl/front_panel_dumper.sv
// Drives a PDP-8 style front panel to read a range of memory words and streams them out.
// Optional DUMP_CHECKSUM_EN adds a mod-4096 running sum of the transferred words.
module front_panel_dumper #(
    parameter int HOLD_CYCLES   = 10,
    parameter int SETTLE_CYCLES = 30
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        start,
    input  logic [11:0] start_addr,
    input  logic [11:0] end_addr,
    output logic [11:0] sw,
    output logic        load_pc_btn,
    output logic        examine_btn,
    input  logic [11:0] led,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_addr,
    output logic [11:0] out_data,
    output logic        busy,
    output logic        done
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [11:0] checksum
`endif
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        SET_SW,
        PRESS_LPC,
        REL_LPC,
        PRESS_EX,
        REL_EX,
        SETTLE,
        EMIT,
        FINISH
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] phase_cnt;
    logic [11:0]   addr;
    logic [12:0]   remaining;
    logic          hold_done;
    logic          settle_done;
    logic          accept;
    logic          xfer;

    always_comb begin
        next_state  = state;
        hold_done   = (phase_cnt == HOLD_LAST);
        settle_done = (phase_cnt == SETTLE_LAST);
        accept      = 1'b0;
        xfer        = 1'b0;
        load_pc_btn = 1'b0;
        examine_btn = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    next_state = SET_SW;
                end
            end
            SET_SW: begin
                if (hold_done) next_state = PRESS_LPC;
            end
            PRESS_LPC: begin
                load_pc_btn = 1'b1;
                if (hold_done) next_state = REL_LPC;
            end
            REL_LPC: begin
                if (hold_done) next_state = PRESS_EX;
            end
            PRESS_EX: begin
                examine_btn = 1'b1;
                if (hold_done) next_state = REL_EX;
            end
            REL_EX: begin
                if (hold_done) next_state = SETTLE;
            end
            SETTLE: begin
                if (settle_done) next_state = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    xfer = 1'b1;
                    // The panel auto-increments its PC on examine, so no reload between words
                    next_state = (remaining == 13'd1) ? FINISH : PRESS_EX;
                end
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state     <= IDLE;
            phase_cnt <= '0;
            addr      <= '0;
            remaining <= '0;
            sw        <= '0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state <= next_state;
            if (next_state != state || state == IDLE || state == EMIT || state == FINISH)
                phase_cnt <= '0;
            else
                phase_cnt <= phase_cnt + 1'b1;
            if (accept) begin
                addr      <= start_addr;
                sw        <= start_addr;
                remaining <= {1'b0, end_addr - start_addr} + 13'd1;
            end
            if (state == SETTLE && settle_done) begin
                out_data <= led;
                out_addr <= addr;
            end
            if (xfer) begin
                addr      <= addr + 12'd1;
                remaining <= remaining - 13'd1;
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (!resetN)
            checksum <= '0;
        else if (accept)
            checksum <= '0;
        else if (xfer)
            checksum <= checksum + out_data;
    end
`endif

endmodule

// File: tb/tb_front_panel_dumper.sv
// Directed bench for front_panel_dumper: a panel model answers examines and a scoreboard
// queue holds the expected (addr, data) stream for each dump.
module tb_front_panel_dumper;

    localparam int HOLD   = 3;
    localparam int SETTLE = 5;

    logic        clock = 1'b0;
    logic        resetN;
    logic        start;
    logic [11:0] start_addr;
    logic [11:0] end_addr;
    logic [11:0] sw;
    logic        load_pc_btn;
    logic        examine_btn;
    logic [11:0] led;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_addr;
    logic [11:0] out_data;
    logic        busy;
    logic        done;
`ifdef DUMP_CHECKSUM_EN
    logic [11:0] checksum;
`endif

    front_panel_dumper #(.HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .sw         (sw),
        .load_pc_btn(load_pc_btn),
        .examine_btn(examine_btn),
        .led        (led),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
`ifdef DUMP_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   xfer_cnt, lpc_pulses, lpc_high, ex_pulses, done_cnt;
    logic const_mode = 1'b0;

    // Panel model: load-address copies switches into PC, examine shows mem[PC] and bumps PC
    logic [11:0] pc = '0;
    logic        lpc_q = 1'b0;
    logic        ex_q  = 1'b0;
    always @(posedge clock) begin
        lpc_q <= load_pc_btn;
        ex_q  <= examine_btn;
        if (load_pc_btn && !lpc_q) pc <= sw;
        if (examine_btn && !ex_q) begin
            led <= const_mode ? 12'o7777 : pc + 12'd1;
            pc  <= pc + 12'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0o expected=%0o", tag, obs, expv);
        end
    endtask

    logic        mon_lpc_prev = 1'b0;
    logic        mon_btn_prev = 1'b0;
    logic [11:0] mon_sw_prev  = '0;
    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_xfer", {20'd0, out_addr}, 32'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("out_addr", {20'd0, out_addr}, {20'd0, e.a});
                checkOutput("out_data", {20'd0, out_data}, {20'd0, e.d});
            end
        end
        if (load_pc_btn && !mon_lpc_prev) lpc_pulses++;
        if (load_pc_btn) lpc_high++;
        if (examine_btn && !mon_btn_prev && !load_pc_btn) ex_pulses++;
        if (done) done_cnt++;
        if (load_pc_btn || examine_btn)
            checkOutput("btn_exclusive", {31'd0, load_pc_btn & examine_btn}, 32'd0);
        if ((load_pc_btn || examine_btn) && mon_btn_prev)
            checkOutput("sw_stable", {20'd0, sw}, {20'd0, mon_sw_prev});
        mon_lpc_prev = load_pc_btn;
        mon_btn_prev = load_pc_btn | examine_btn;
        mon_sw_prev  = sw;
    end

    task automatic clearCounts();
        xfer_cnt   = 0;
        lpc_pulses = 0;
        lpc_high   = 0;
        ex_pulses  = 0;
        done_cnt   = 0;
    endtask

    task automatic pushRange(input logic [11:0] s, input logic [11:0] e);
        logic [11:0] n;
        logic [11:0] a;
        n = e - s;
        for (int i = 0; i <= int'(n); i++) begin
            a = s + 12'(i);
            exp_q.push_back({a, const_mode ? 12'o7777 : a + 12'd1});
        end
    endtask

    task automatic applyStimulus(input logic [11:0] s, input logic [11:0] e);
        pushRange(s, e);
        @(posedge clock);
        #1;
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, output logic [11:0] cks);
        logic seen;
        seen = 1'b0;
        cks  = '0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                cks = checksum;
`endif
            end
        end
        checkOutput(tag, {31'd0, seen}, 32'd1);
        @(negedge clock);
        checkOutput({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done_1clk"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    logic [11:0] cks;
    logic [11:0] held_addr;
    logic [11:0] held_data;
    logic        stable;
    logic        seen_valid;
    int          ex_before;

    initial begin
        resetN     = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        out_ready  = 1'b1;
        clearCounts();
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_sw", {20'd0, sw}, 32'd0);
        checkOutput("rst_lpc", {31'd0, load_pc_btn}, 32'd0);
        checkOutput("rst_ex", {31'd0, examine_btn}, 32'd0);
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_addr", {20'd0, out_addr}, 32'd0);
        checkOutput("rst_out_data", {20'd0, out_data}, 32'd0);
        resetN = 1'b1;

        // Basic four-word dump
        clearCounts();
        applyStimulus(12'o0200, 12'o0203);
        checkOutput("t1_busy", {31'd0, busy}, 32'd1);
        waitDone("t1_done", cks);
        checkOutput("t1_xfers", xfer_cnt, 32'd4);
        checkOutput("t1_lpc_pulses", lpc_pulses, 32'd1);
        checkOutput("t1_ex_pulses", ex_pulses, 32'd4);
        checkOutput("t1_done_pulses", done_cnt, 32'd1);

        // Wrap through 7777
        clearCounts();
        applyStimulus(12'o7776, 12'o0001);
        waitDone("t2_done", cks);
        checkOutput("t2_xfers", xfer_cnt, 32'd4);
        checkOutput("t2_done_pulses", done_cnt, 32'd1);

        // Backpressure in EMIT
        clearCounts();
        out_ready = 1'b0;
        applyStimulus(12'o0300, 12'o0301);
        seen_valid = 1'b0;
        for (int i = 0; i < 500 && !seen_valid; i++) begin
            @(negedge clock);
            if (out_valid) seen_valid = 1'b1;
        end
        checkOutput("t3_valid_seen", {31'd0, seen_valid}, 32'd1);
        held_addr = out_addr;
        held_data = out_data;
        ex_before = ex_pulses;
        stable    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!out_valid || out_addr !== held_addr || out_data !== held_data) stable = 1'b0;
        end
        checkOutput("t3_stable", {31'd0, stable}, 32'd1);
        checkOutput("t3_held_addr", {20'd0, held_addr}, {20'd0, 12'o0300});
        checkOutput("t3_no_examine", ex_pulses, ex_before);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        waitDone("t3_done", cks);
        checkOutput("t3_xfers", xfer_cnt, 32'd2);

        // Reset while examine is pressed
        clearCounts();
        applyStimulus(12'o0400, 12'o0402);
        seen_valid = 1'b0;
        for (int i = 0; i < 500 && !seen_valid; i++) begin
            @(posedge clock);
            #1;
            if (examine_btn) seen_valid = 1'b1;
        end
        checkOutput("t4_ex_seen", {31'd0, seen_valid}, 32'd1);
        resetN = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("t4_ex_released", {31'd0, examine_btn}, 32'd0);
        checkOutput("t4_busy", {31'd0, busy}, 32'd0);
        checkOutput("t4_valid", {31'd0, out_valid}, 32'd0);
        resetN = 1'b1;
        exp_q.delete();
        repeat (10) @(posedge clock);
        #1;
        checkOutput("t4_still_idle", {31'd0, busy}, 32'd0);
        checkOutput("t4_no_done", done_cnt, 32'd0);

        // Single word; a second start while busy must be ignored
        clearCounts();
        applyStimulus(12'o0100, 12'o0100);
        start_addr = 12'o0500;
        end_addr   = 12'o0510;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        waitDone("t5_done", cks);
        checkOutput("t5_xfers", xfer_cnt, 32'd1);
        checkOutput("t5_lpc_high", lpc_high, HOLD);
        checkOutput("t5_ex_pulses", ex_pulses, 32'd1);
        checkOutput("t5_done_pulses", done_cnt, 32'd1);

`ifdef DUMP_CHECKSUM_EN
        clearCounts();
        const_mode = 1'b1;
        applyStimulus(12'o0200, 12'o0203);
        waitDone("t6_done", cks);
        checkOutput("t6_checksum", {20'd0, cks}, {20'd0, 12'o7774});
        const_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
